// File: rtl/fixmul_writeback_unit_if.sv
// Multiply issue, decode hazard, and register-file write-port signals of fixmul_writeback_unit.
// The pipeline side uses the master modport and the unit uses the slave modport.
interface fixmul_writeback_unit_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        pipe_regwrite;
    logic [4:0]  pipe_writereg;
    logic [31:0] pipe_writedata;
    logic        f_regwrite;
    logic [4:0]  writereg;
    logic [31:0] writedata;
    logic        busy;
    logic        done;
    logic        stall;

    modport master (
        output start, a, b, dest, rs, rt, rd,
        output pipe_regwrite, pipe_writereg, pipe_writedata,
        input  f_regwrite, writereg, writedata, busy, done, stall
    );

    modport slave (
        input  start, a, b, dest, rs, rt, rd,
        input  pipe_regwrite, pipe_writereg, pipe_writedata,
        output f_regwrite, writereg, writedata, busy, done, stall
    );
endinterface

// File: rtl/fixmul_writeback_unit.sv
// Iterative signed Q16.16 multiplier that owns the register-file write port; FIXMUL_SATURATE_EN clamps overflow.
// Latency: start at edge N, result offered in WAIT_WB during the cycle after edge N+32.
// Backpressure: pipeline writeback always wins; the pending result is held, and decode is stalled on hazards.
module fixmul_writeback_unit #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    fixmul_writeback_unit_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, WAIT_WB} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    acc;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             sign;
    logic [4:0]       dest_q;
    logic             done_q;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             grant;
    logic             unit_wr;

    // Two's-complement negation of 0x80000000 yields 0x80000000, i.e. magnitude 2^31 when read unsigned.
    assign abs_a = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
    assign abs_b = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;

    assign busy    = (state != IDLE);
    assign unit_wr = (state == WAIT_WB) && (dest_q != 5'd0);
    assign grant   = (state == WAIT_WB) && (!bus.pipe_regwrite || dest_q == 5'd0);

`ifdef FIXMUL_SATURATE_EN
    localparam int MW = PW - FRAC_BITS;
    localparam logic [WIDTH-1:0] POS_LIM = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_LIM = {1'b1, {(WIDTH-1){1'b0}}};

    logic [MW-1:0] m;
    assign m = acc[PW-1:FRAC_BITS];

    always_comb begin
        result = m[WIDTH-1:0];
        if (sign) begin
            if (m > {{(MW-WIDTH){1'b0}}, NEG_LIM}) result = NEG_LIM;
            else                                   result = ~m[WIDTH-1:0] + 1'b1;
        end else if (m > {{(MW-WIDTH){1'b0}}, POS_LIM}) begin
            result = POS_LIM;
        end
    end
`else
    // Only the low WIDTH bits of the truncated magnitude survive wrap-around.
    logic [WIDTH-1:0] m_lo;
    assign m_lo   = acc[FRAC_BITS +: WIDTH];
    assign result = sign ? (~m_lo + 1'b1) : m_lo;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            sign   <= 1'b0;
            dest_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= grant;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        sign   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        dest_q <= bus.dest;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (mag_b[cnt]) acc <= acc + ({{WIDTH{1'b0}}, mag_a} << cnt);
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= WAIT_WB;
                end
                WAIT_WB: begin
                    if (grant) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.f_regwrite = bus.pipe_regwrite;
        bus.writereg   = bus.pipe_writereg;
        bus.writedata  = bus.pipe_writedata;
        if (!bus.pipe_regwrite && unit_wr) begin
            bus.f_regwrite = 1'b1;
            bus.writereg   = dest_q;
            bus.writedata  = result;
        end
    end

    assign bus.busy  = busy;
    assign bus.done  = done_q;
    // A second issue stalls too, since start is ignored while busy.
    assign bus.stall = busy && (((dest_q != 5'd0) &&
                                 (bus.rs == dest_q || bus.rt == dest_q || bus.rd == dest_q)) ||
                                bus.start);
endmodule

// File: tb/tb_fixmul_writeback_unit.sv
// Directed bench for fixmul_writeback_unit: expected writes are queued at issue, a negedge monitor retires them.
module tb_fixmul_writeback_unit;
    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    typedef struct packed {
        logic [4:0]  wreg;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    fixmul_writeback_unit_if bus();

    fixmul_writeback_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every unit-originated write must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && bus.f_regwrite === 1'b1 && bus.pipe_regwrite === 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got reg %0d data %h expected no write",
                         bus.writereg, bus.writedata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_reg", 32'(bus.writereg), 32'(e.wreg));
                chk("wr_data", bus.writedata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic [4:0] dv,
                         input logic [31:0] ev, input bit push);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.dest  = dv;
        if (push && dv != 5'd0) exp_q.push_back('{wreg: dv, data: ev});
        tick();
        bus.start = 1'b0;
    endtask

    // Entered just after accept edge N + (31 - n); finishes just after edge N+34.
    task automatic finish_mul(input logic [4:0] dv, input int n);
        repeat (n) tick();
        @(negedge clk);
        chk("busy_calc", 32'(bus.busy), 32'd1);
        chk("no_early_wr", 32'(bus.f_regwrite), 32'd0);
        tick();
        @(negedge clk);
        chk("wr_en", 32'(bus.f_regwrite), (dv != 5'd0) ? 32'd1 : 32'd0);
        chk("busy_wait", 32'(bus.busy), 32'd1);
        chk("done_early", 32'(bus.done), 32'd0);
        tick();
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("busy_after", 32'(bus.busy), 32'd0);
        chk("no_wr_after", 32'(bus.f_regwrite), 32'd0);
        tick();
        @(negedge clk);
        chk("done_single", 32'(bus.done), 32'd0);
    endtask

    task automatic run_mul(input logic [31:0] av, input logic [31:0] bv, input logic [4:0] dv,
                           input logic [31:0] ev);
        issue(av, bv, dv, ev, 1'b1);
        finish_mul(dv, 31);
    endtask

    initial begin
        reset              = 1'b1;
        bus.start          = 1'b0;
        bus.a              = '0;
        bus.b              = '0;
        bus.dest           = '0;
        bus.rs             = '0;
        bus.rt             = '0;
        bus.rd             = '0;
        bus.pipe_regwrite  = 1'b1;
        bus.pipe_writereg  = 5'd7;
        bus.pipe_writedata = 32'hCAFE_0001;
        tick();
        tick();
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_pass_en", 32'(bus.f_regwrite), 32'd1);
        chk("rst_pass_reg", 32'(bus.writereg), 32'd7);
        chk("rst_pass_data", bus.writedata, 32'hCAFE_0001);
        tick();
        reset             = 1'b0;
        bus.pipe_regwrite = 1'b0;

        // -1.5 * 2.0 = -3.0
        run_mul(32'hFFFE_8000, 32'h0002_0000, 5'd5, 32'hFFFD_0000);

        // Pipeline owns the port for the first three WAIT_WB cycles.
        issue(32'hFFFE_8000, 32'h0002_0000, 5'd5, 32'hFFFD_0000, 1'b1);
        repeat (31) tick();
        bus.pipe_regwrite  = 1'b1;
        bus.pipe_writereg  = 5'd7;
        bus.pipe_writedata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("arb_pipe_en", 32'(bus.f_regwrite), 32'd1);
            chk("arb_pipe_reg", 32'(bus.writereg), 32'd7);
            chk("arb_pipe_data", bus.writedata, 32'h1234_5678);
            chk("arb_held_busy", 32'(bus.busy), 32'd1);
        end
        tick();
        bus.pipe_regwrite = 1'b0;
        @(negedge clk);
        chk("arb_unit_en", 32'(bus.f_regwrite), 32'd1);
        chk("arb_done_wait", 32'(bus.done), 32'd0);
        tick();
        @(negedge clk);
        chk("arb_done", 32'(bus.done), 32'd1);
        tick();

`ifdef FIXMUL_SATURATE_EN
        run_mul(32'h7FFF_0000, 32'h0002_0000, 5'd6, 32'h7FFF_FFFF);
`else
        run_mul(32'h7FFF_0000, 32'h0002_0000, 5'd6, 32'hFFFE_0000);
`endif

        // Hazards against pending dest=9 (1.0 * 1.0).
        issue(32'h0001_0000, 32'h0001_0000, 5'd9, 32'h0001_0000, 1'b1);
        bus.rs = 5'd9;
        @(negedge clk);
        chk("stall_rs", 32'(bus.stall), 32'd1);
        tick();
        bus.rs = 5'd0;
        bus.rt = 5'd3;
        bus.rd = 5'd9;
        @(negedge clk);
        chk("stall_rd", 32'(bus.stall), 32'd1);
        tick();
        bus.rs = 5'd1;
        bus.rt = 5'd2;
        bus.rd = 5'd3;
        @(negedge clk);
        chk("stall_none", 32'(bus.stall), 32'd0);
        repeat (29) tick();
        bus.rs = 5'd9;
        tick();
        @(negedge clk);
        chk("haz_wr", 32'(bus.f_regwrite), 32'd1);
        chk("stall_wait", 32'(bus.stall), 32'd1);
        tick();
        @(negedge clk);
        chk("stall_released", 32'(bus.stall), 32'd0);
        chk("haz_done", 32'(bus.done), 32'd1);
        tick();
        bus.rs = 5'd0;
        bus.rt = 5'd0;
        bus.rd = 5'd0;

        // dest=0: no stall against r0, result discarded, done still pulses.
        issue(32'h0002_0000, 32'h0003_0000, 5'd0, 32'h0006_0000, 1'b1);
        @(negedge clk);
        chk("stall_r0", 32'(bus.stall), 32'd0);
        finish_mul(5'd0, 31);

        // Reset at counter=12 aborts with no write and no done.
        issue(32'h0005_0000, 32'h0007_0000, 5'd8, 32'h0023_0000, 1'b0);
        repeat (12) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_wr", 32'(bus.f_regwrite), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("abort_done_quiet", 32'(bus.done), 32'd0);
        end
        tick();
        // 5.0 * 7.0 = 35.0
        run_mul(32'h0005_0000, 32'h0007_0000, 5'd8, 32'h0023_0000);

        // Second start while busy is ignored and stalls.
        issue(32'h0001_0000, 32'h0003_0000, 5'd4, 32'h0003_0000, 1'b1);
        repeat (4) tick();
        bus.start = 1'b1;
        bus.a     = 32'h7FFF_0000;
        bus.b     = 32'h7FFF_0000;
        bus.dest  = 5'd6;
        @(negedge clk);
        chk("stall_restart", 32'(bus.stall), 32'd1);
        tick();
        @(negedge clk);
        chk("stall_restart2", 32'(bus.stall), 32'd1);
        bus.start = 1'b0;
        finish_mul(5'd4, 26);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_writes: got %0d pending expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
